sbus_mem_arbiter: RTL
=====================

Name: sbus_mem_arbiter

Overview:
- Parametrised SimpleBus memory front-end: N masters (IFU, LSU, future DMA) share one single-ported memory port.
- Round-robin or fixed-priority arbitration with a programmable fixed response latency.
- Replaces the per-channel hard-coded delay counters in the top level.
- Memory side is the registered DPI memory: read data is available the cycle after the strobe.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=1)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- LATENCY, 3, cycles from request acceptance to respValid (>=2)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- m_reqValid  in  N_MASTERS  per-master request valid
- m_reqReady  out  N_MASTERS  per-master accept (one-hot or zero)
- m_addr  in  N_MASTERS*AW  per-master byte address; master i occupies slice i
- m_wen  in  N_MASTERS  1 = write, 0 = read
- m_wdata  in  N_MASTERS*DW  per-master write data
- m_wmask  in  N_MASTERS*DW/8  per-master byte-enable
- m_respValid  out  N_MASTERS  one-cycle response pulse to the owning master
- m_rdata  out  N_MASTERS*DW  read data; nonzero only in the owner's slice
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_wmask  out  DW/8  memory byte-enable
- mem_rdata  in  DW  memory read data, valid the cycle after mem_ren
- busy  out  1  transaction in flight
- grant_id  out  clog2(N_MASTERS) (min 1)  index of current or last owner

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - All outputs go to 0.
  - RR pointer goes to N_MASTERS-1, so master 0 is first.
  - Latched request and rdata_q are cleared.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any m_reqValid, select winner g and assert m_reqReady[g] combinationally this cycle (T).
  - At the edge, latch addr/wen/wdata/wmask of g, set grant_id=g, go to ACCESS.
  - busy=1 from T+1.
  - With no requests, stay in IDLE; reqReady is all zero.
- ACCESS (cycle T+1):
  - Drive mem_ren=!wen or mem_wen=wen for exactly one cycle, plus the latched addr/wdata/wmask.
  - Go to WAIT if LATENCY>2, else RESP.
- Read data capture: mem_rdata is captured into rdata_q at the end of T+2.
- WAIT:
  - Down-counter loaded with LATENCY-3 on entering WAIT.
  - Go to RESP when the counter reaches 0.
  - Counter width is clog2(LATENCY+1).
- RESP (cycle T+LATENCY):
  - m_respValid[g]=1 for exactly one cycle.
  - m_rdata slice g = rdata_q for reads, 0 for writes; all other slices 0.
  - Next state is IDLE and busy drops.
  - No acceptance occurs in RESP, so throughput is 1 transaction per LATENCY+1 cycles.
- Round-robin (PRIO_MODE=0):
  - Winner is the first valid master searching ptr+1, ptr+2, … modulo N_MASTERS.
  - ptr is updated to g only on acceptance.
- Fixed priority (PRIO_MODE=1): winner is the lowest-index valid master; ptr is unused.
- Request stability: masters must hold request fields stable until reqReady.
  - A reqValid deasserted before acceptance is simply not granted.
  - It is not an error.
- Requests during busy: m_reqReady stays 0 and requests wait; no queueing beyond the single in-flight transaction.
- Strobes: mem_ren and mem_wen are never high together and are high in at most one cycle per transaction.
- Reset mid-transaction:
  - Abort immediately; no respValid follows.
  - A write already strobed stays committed.
- Elaboration: LATENCY<2 or N_MASTERS<1 is a fatal elaboration error.

Test Plan:
- Read at LATENCY=3, master 0 reads addr 0x80000000, memory returns 0x00100073 → reqReady[0] at cycle 0, mem_ren at cycle 1 with addr 0x80000000, respValid[0] at cycle 3 with rdata 0x00100073, and m_rdata slice 1 = 0.
- Round-robin fairness, both masters hold reqValid continuously in PRIO_MODE=0 → grants 0,1,0,1 on accept cycles 0,4,8,12.
- Fixed priority, same stimulus in PRIO_MODE=1 → master 0 granted every transaction and master 1 never; after master 0 drops, master 1 is granted on the next IDLE cycle.
- Write, master 1 writes addr 0x80000010, wdata 0xdeadbeef, wmask 0xf → one cycle of mem_wen with those values, mem_ren never high, respValid[1] with rdata 0.
- Reset mid-op, rst=0 during WAIT of a read → next cycle busy=0 with no respValid; the first request after release is granted to master 0.
- Latency sweep, LATENCY=2 and LATENCY=8 with back-to-back reads → respValid at T+2 and T+8 respectively, and accept-to-accept spacing of 3 and 9 cycles.

Source files
------------

// File: rtl/sbus_mem_arbiter.sv
// sbus_mem_arbiter
//   SimpleBus memory front-end. N_MASTERS requesters share one single-ported,
//   registered memory port (read data appears the cycle after mem_ren). One
//   transaction is in flight at a time. Every transaction responds exactly
//   LATENCY cycles after it is accepted.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-low
//   m_reqValid   per-master request valid
//   m_reqReady   per-master accept, one-hot or zero, combinational in IDLE
//   m_addr       per-master byte address, master i in slice i
//   m_wen        per-master write enable (1 = write, 0 = read)
//   m_wdata      per-master write data
//   m_wmask      per-master byte enables
//   m_respValid  one-cycle response pulse to the owning master
//   m_rdata      read data, nonzero only in the owner's slice
//   mem_ren      memory read strobe
//   mem_wen      memory write strobe
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_wmask    memory byte enables
//   mem_rdata    memory read data, valid the cycle after mem_ren
//   busy         transaction in flight
//   grant_id     index of the current or last owner
module sbus_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LATENCY   = 3,
  parameter int PRIO_MODE = 0,
  localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_reqValid,
  output logic [N_MASTERS-1:0]        m_reqReady,
  input  logic [N_MASTERS*AW-1:0]     m_addr,
  input  logic [N_MASTERS-1:0]        m_wen,
  input  logic [N_MASTERS*DW-1:0]     m_wdata,
  input  logic [N_MASTERS*DW/8-1:0]   m_wmask,
  output logic [N_MASTERS-1:0]        m_respValid,
  output logic [N_MASTERS*DW-1:0]     m_rdata,
  output logic                        mem_ren,
  output logic                        mem_wen,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  output logic [DW/8-1:0]             mem_wmask,
  input  logic [DW-1:0]               mem_rdata,
  output logic                        busy,
  output logic [GW-1:0]               grant_id
);

  localparam int BW   = DW / 8;
  localparam int CW   = $clog2(LATENCY + 1);
  localparam int WAIT_LOAD = (LATENCY > 2) ? (LATENCY - 3) : 0;

  generate
    if (LATENCY < 2 || N_MASTERS < 1) begin : g_bad_params
      $fatal(1, "sbus_mem_arbiter: LATENCY must be >= 2 and N_MASTERS >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_ptr, r_gid, w_gnt;
  logic            w_any, w_accept;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [BW-1:0]   r_wmask;
  logic [DW-1:0]   r_rdata_q;
  logic            r_cap;
  logic [DW-1:0]   w_rdata;

  // Candidate order: fixed priority scans 0..N-1, round-robin scans from ptr+1.
  function automatic int pick_idx(input int k, input logic [GW-1:0] ptr);
    if (PRIO_MODE == 1) return k;
    return (int'(ptr) + 1 + k) % N_MASTERS;
  endfunction

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!w_any && m_reqValid[GW'(pick_idx(k, r_ptr))]) begin
        w_any = 1'b1;
        w_gnt = GW'(pick_idx(k, r_ptr));
      end
    end
  end

  // Gating with rst keeps reqReady low during a reset cycle so nothing is
  // reported as accepted while the edge is about to discard it.
  assign w_accept = rst && (r_state == S_IDLE) && w_any;

  always_comb begin
    m_reqReady = '0;
    if (w_accept) m_reqReady[w_gnt] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ACCESS;
      S_ACCESS: w_next = (LATENCY > 2) ? S_WAIT : S_RESP;
      S_WAIT:   if (r_cnt == '0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr     <= GW'(N_MASTERS - 1);
      r_gid     <= '0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_cnt     <= '0;
      r_cap     <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      if (w_accept) begin
        r_ptr   <= w_gnt;
        r_gid   <= w_gnt;
        r_addr  <= m_addr[int'(w_gnt)*AW +: AW];
        r_wen   <= m_wen[w_gnt];
        r_wdata <= m_wdata[int'(w_gnt)*DW +: DW];
        r_wmask <= m_wmask[int'(w_gnt)*BW +: BW];
      end
      if (r_state == S_ACCESS)
        r_cnt <= CW'(WAIT_LOAD);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      // Registered memory: data for the ACCESS-cycle strobe is on mem_rdata
      // during the following cycle, so capture at the end of that cycle.
      r_cap <= (r_state == S_ACCESS) && !r_wen;
      if (r_cap) r_rdata_q <= mem_rdata;
    end
  end

  // With LATENCY==2 the response cycle is the capture cycle itself, so the
  // memory output is forwarded directly instead of the captured copy.
  assign w_rdata = (LATENCY == 2) ? mem_rdata : r_rdata_q;

  always_comb begin
    m_respValid = '0;
    m_rdata     = '0;
    if (r_state == S_RESP) begin
      m_respValid[r_gid] = 1'b1;
      if (!r_wen) m_rdata[int'(r_gid)*DW +: DW] = w_rdata;
    end
  end

  assign mem_ren   = (r_state == S_ACCESS) && !r_wen;
  assign mem_wen   = (r_state == S_ACCESS) && r_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_gid;

endmodule
